// File: rtl/caeco_stream_rx_if.sv
// Halfword-in / word-out port bundle of the CAECO receive front end.
// slave is the receiver's view; master is the bridge-plus-consumer side that drives it.
interface caeco_stream_rx_if #(
  parameter int ADDR_W = 3
) ();

  logic [15:0]     din;
  logic            din_valid;
  logic            din_ready;
  logic            din_last;
  logic            cmd;
  logic [31:0]     word_data;
  logic            word_valid;
  logic            word_ready;
  logic            word_last;
  logic [ADDR_W:0] level;
  logic            overflow;
  logic            half_pending;

  modport slave (
    input  din, din_valid, din_last, cmd, word_ready,
    output din_ready, word_data, word_valid, word_last, level, overflow, half_pending
  );

  modport master (
    output din, din_valid, din_last, cmd, word_ready,
    input  din_ready, word_data, word_valid, word_last, level, overflow, half_pending
  );

endinterface

// File: rtl/caeco_stream_rx.sv
// CAECO data-port receiver: rebuilds 32-bit words from halfword beats into a FWFT FIFO.
// Optional macro CAECO_RX_BYTESWAP_EN undoes the bridge's byte swap within each half.
module caeco_stream_rx #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  caeco_stream_rx_if.slave   bus
);

  typedef enum logic [1:0] {
    HI    = 2'd0,
    LO    = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [15:0]       hold_q, hold_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              overflow_q, overflow_d;

  logic [32:0]       mem_q [DEPTH];
  logic [32:0]       head;
  logic [15:0]       din_fixed;
  logic              din_ready;
  logic              accept;
  logic              push;
  logic              pop;
  logic [31:0]       push_data;
  logic              push_last;
  logic              not_empty;

`ifdef CAECO_RX_BYTESWAP_EN
  assign din_fixed = {bus.din[7:0], bus.din[15:8]};
`else
  assign din_fixed = bus.din;
`endif

  // Ready depends only on registered state so the bridge never sees a combinational path.
  assign din_ready = (state_q != FLUSH) && (level_q != FULL_LEVEL);
  assign not_empty = (level_q != '0);
  assign accept    = bus.din_valid && din_ready && !bus.cmd;
  assign pop       = not_empty && bus.word_ready && !bus.cmd;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    push      = 1'b0;
    push_data = {din_fixed, 16'h0000};
    push_last = 1'b1;

    case (state_q)
      HI: begin
        if (accept) begin
          if (bus.din_last) begin
            push = 1'b1;
          end else begin
            hold_d  = din_fixed;
            state_d = LO;
          end
        end
      end
      LO: begin
        if (accept) begin
          push      = 1'b1;
          push_data = {hold_q, din_fixed};
          push_last = bus.din_last;
          state_d   = HI;
        end
      end
      FLUSH:   state_d = HI;
      default: state_d = HI;
    endcase

    if (bus.cmd) begin
      state_d = FLUSH;
      hold_d  = '0;
    end
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;

    case ({push, pop})
      2'b10:   level_d = level_q + (ADDR_W + 1)'(1);
      2'b01:   level_d = level_q - (ADDR_W + 1)'(1);
      default: level_d = level_q;
    endcase

    // Beats offered during FLUSH are dropped silently rather than flagged.
    if (bus.din_valid && !din_ready && (state_q != FLUSH)) begin
      overflow_d = 1'b1;
    end

    if (bus.cmd) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HI;
      hold_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {push_last, push_data};
    end
  end

  assign head = mem_q[rd_ptr_q];

  assign bus.din_ready    = din_ready;
  assign bus.word_valid   = not_empty;
  assign bus.word_data    = not_empty ? head[31:0] : 32'h0000_0000;
  assign bus.word_last    = not_empty ? head[32] : 1'b0;
  assign bus.level        = level_q;
  assign bus.overflow     = overflow_q;
  assign bus.half_pending = (state_q == LO);

endmodule

// File: tb/tb_caeco_stream_rx.sv
// Randomised and directed bench for caeco_stream_rx against a queue-based word model.
// Works in both builds; the model follows CAECO_RX_BYTESWAP_EN the same way.
module tb_caeco_stream_rx;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

`ifdef CAECO_RX_BYTESWAP_EN
  localparam logic [15:0] HI_BEAT   = 16'h3412;
  localparam logic [15:0] LO_BEAT   = 16'h7856;
  localparam logic [31:0] LAST_WORD = 32'hDEAD0000;
`else
  localparam logic [15:0] HI_BEAT   = 16'h1234;
  localparam logic [15:0] LO_BEAT   = 16'h5678;
  localparam logic [31:0] LAST_WORD = 32'hADDE0000;
`endif

  logic clk;
  logic rst;

  caeco_stream_rx_if #(.ADDR_W(ADDR_W)) bus ();

  caeco_stream_rx #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int totalChecks = 0;
  int badChecks   = 0;

  // Reference model: a queue of {last, word}, the pending high half, and flags.
  logic [32:0] expQ[$];
  logic [15:0] heldHalf;
  bit          pending;
  bit          expOverflow;
  bit          inFlush;

  function automatic logic [15:0] fixHalf(input logic [15:0] d);
`ifdef CAECO_RX_BYTESWAP_EN
    return {d[7:0], d[15:8]};
`else
    return d;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic resetModel();
    expQ.delete();
    heldHalf    = '0;
    pending     = 1'b0;
    expOverflow = 1'b0;
    inFlush     = 1'b0;
  endtask

  task automatic checkAll();
    bit          hasWord;
    logic [32:0] headWord;
    hasWord  = (expQ.size() > 0);
    headWord = hasWord ? expQ[0] : 33'h0;
    checkOutput("din_ready",    64'(bus.din_ready),    64'(!inFlush && expQ.size() < DEPTH));
    checkOutput("word_valid",   64'(bus.word_valid),   64'(hasWord));
    checkOutput("word_data",    64'(bus.word_data),    64'(headWord[31:0]));
    checkOutput("word_last",    64'(bus.word_last),    64'(headWord[32]));
    checkOutput("level",        64'(bus.level),        64'(expQ.size()));
    checkOutput("overflow",     64'(bus.overflow),     64'(expOverflow));
    checkOutput("half_pending", 64'(bus.half_pending), 64'(pending));
  endtask

  // Drives one cycle of inputs, advances the model across the edge, then checks.
  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic l,
                               input logic c, input logic wr);
    bit preReady;
    bit prePop;
    bus.din        = d;
    bus.din_valid  = v;
    bus.din_last   = l;
    bus.cmd        = c;
    bus.word_ready = wr;
    preReady = !inFlush && (expQ.size() < DEPTH);
    prePop   = (expQ.size() > 0) && wr;
    @(posedge clk);
    if (c) begin
      expQ.delete();
      pending     = 1'b0;
      expOverflow = 1'b0;
      inFlush     = 1'b1;
    end else begin
      if (prePop) void'(expQ.pop_front());
      if (v && !preReady && !inFlush) expOverflow = 1'b1;
      if (v && preReady) begin
        if (!pending) begin
          if (l) expQ.push_back({1'b1, fixHalf(d), 16'h0000});
          else begin
            heldHalf = fixHalf(d);
            pending  = 1'b1;
          end
        end else begin
          expQ.push_back({l, heldHalf, fixHalf(d)});
          pending = 1'b0;
        end
      end
      inFlush = 1'b0;
    end
    @(negedge clk);
    checkAll();
  endtask

  task automatic idle(input logic wr);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, wr);
  endtask

  initial begin
    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.din_last   = 1'b0;
    bus.cmd        = 1'b0;
    bus.word_ready = 1'b0;
    rst            = 1'b1;
    resetModel();
    repeat (2) @(negedge clk);
    checkAll();
    rst = 1'b0;

    // Basic reassembly and fall-through latency.
    applyStimulus(1'b1, HI_BEAT, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, LO_BEAT, 1'b0, 1'b0, 1'b0);
    checkOutput("first_word", 64'(bus.word_data), 64'h12345678);
    idle(1'b1);

    // Fill to full, then one beat too many.
    for (int i = 0; i < 2 * DEPTH; i++) begin
      applyStimulus(1'b1, 16'(i * 16'h1111 + 16'h0102), 1'b0, 1'b0, 1'b0);
    end
    checkOutput("full_ready", 64'(bus.din_ready), 64'd0);
    applyStimulus(1'b1, 16'hCAFE, 1'b0, 1'b0, 1'b0);
    checkOutput("full_overflow", 64'(bus.overflow), 64'd1);

    // Pop while full with a beat offered: pop happens, beat dropped.
    applyStimulus(1'b1, 16'hF00D, 1'b0, 1'b0, 1'b1);
    checkOutput("after_pop_level", 64'(bus.level), 64'(DEPTH - 1));

    // Resync in the middle of a word.
    idle(1'b0);
    applyStimulus(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    checkOutput("flush_ready", 64'(bus.din_ready), 64'd0);
    applyStimulus(1'b1, 16'h9999, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, HI_BEAT, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, LO_BEAT, 1'b0, 1'b0, 1'b0);
    checkOutput("resync_word", 64'(bus.word_data), 64'h12345678);
    idle(1'b1);

    // Lone high half marked last.
    applyStimulus(1'b1, 16'hADDE, 1'b1, 1'b0, 1'b0);
    checkOutput("last_only_word", 64'(bus.word_data), 64'(LAST_WORD));
    checkOutput("last_only_flag", 64'(bus.word_last), 64'd1);
    idle(1'b1);

    // Asynchronous reset with a half held.
    applyStimulus(1'b1, HI_BEAT, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    resetModel();
    checkAll();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, HI_BEAT, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, LO_BEAT, 1'b0, 1'b0, 1'b0);
    checkOutput("post_reset_word", 64'(bus.word_data), 64'h12345678);

    // Random traffic with occasional resyncs and back-pressure.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'($urandom_range(0, 99) < 70),
                    16'($urandom),
                    1'($urandom_range(0, 99) < 20),
                    1'($urandom_range(0, 99) < 3),
                    1'($urandom_range(0, 99) < 40));
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
